// File: rtl/ram_sp_responder.sv
// Single-port block-RAM responder: clears the array after reset, then serves
// en/we/addr/din requests with a 1- or 2-stage registered read path.
module ram_sp_responder #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned WRITE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              dout_valid,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_valid_q;
  logic              ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign ready   = (state_q == StReady);
  assign busy    = ~ready;
  assign rd_data = mem[addra];

  // The clear sequencer borrows the single write port; writes are held off
  // while rst is asserted so the array is never disturbed during reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addra;
    mem_wdata = dina;
    if (!ready) begin
      mem_we    = ~rst;
      mem_addr  = clr_cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we = ena & wea;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= StReady;
          end
        end
        StReady: begin
          if (ena) begin
            s1_data_q  <= (WRITE_MODE == 1 && wea) ? dina : rd_data;
            s1_valid_q <= ~wea;
          end else begin
            s1_valid_q <= 1'b0;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else if (ready) begin
        s2_data_q  <= s1_data_q;
        s2_valid_q <= s1_valid_q;
      end
    end

    assign douta      = s2_data_q;
    assign dout_valid = s2_valid_q;
  end else begin : g_lat1
    assign douta      = s1_data_q;
    assign dout_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_ram_sp_responder.sv
// Directed bench: three responders (read-first L1, write-first L1, read-first L2)
// share one request stream; each task checks its own scenario inline.
module tb_ram_sp_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       wea = 1'b0;
  logic [3:0] addra = '0;
  logic [7:0] dina = '0;
  logic [7:0] dout_rf, dout_wf, dout_l2;
  logic       val_rf, val_wf, val_l2;
  logic       busy_rf, busy_wf, busy_l2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_sp_responder #(.ADDR_W(4), .DATA_W(8), .LATENCY(1), .WRITE_MODE(0)) dut_rf (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout_rf), .dout_valid(val_rf), .busy(busy_rf)
  );

  ram_sp_responder #(.ADDR_W(4), .DATA_W(8), .LATENCY(1), .WRITE_MODE(1)) dut_wf (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout_wf), .dout_valid(val_wf), .busy(busy_wf)
  );

  ram_sp_responder #(.ADDR_W(4), .DATA_W(8), .LATENCY(2), .WRITE_MODE(0)) dut_l2 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout_l2), .dout_valid(val_l2), .busy(busy_l2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [3:0] a, input logic [7:0] d);
    ena   = e;
    wea   = w;
    addra = a;
    dina  = d;
  endtask

  // Counts edges until busy drops; expects exactly 16 for a 16-word array.
  task automatic wait_clear(input string name);
    int n = 0;
    while (busy_rf && n < 40) begin
      tick();
      n++;
    end
    n_vec++;
    if (n !== 16 || busy_l2 !== 1'b0 || busy_wf !== 1'b0) begin
      n_err++;
      $display("FAIL %s: busy edges=%0d (l2 busy=%b wf busy=%b), required 16 and all idle",
               name, n, busy_l2, busy_wf);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({dout_rf, val_rf, busy_rf} !== {8'h00, 1'b0, 1'b1} ||
        {dout_l2, val_l2, busy_l2} !== {8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: rf=%h/%b/%b l2=%h/%b/%b, required 00/0/1",
               dout_rf, val_rf, busy_rf, dout_l2, val_l2, busy_l2);
    end
    rst = 1'b0;
    wait_clear("clear_length");
    drive(1'b1, 1'b0, 4'd15, 8'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    n_vec++;
    if (dout_rf !== 8'h00 || val_rf !== 1'b1) begin
      n_err++;
      $display("FAIL clear_read15: douta=%h valid=%b, required 00/1", dout_rf, val_rf);
    end
    tick();
    n_vec++;
    if (val_rf !== 1'b0) begin
      n_err++;
      $display("FAIL valid_strobe: valid=%b, required 0", val_rf);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 4'd0, 8'd23);
    tick();
    drive(1'b1, 1'b1, 4'd1, 8'd45);
    tick();
    drive(1'b1, 1'b0, 4'd1, 8'd79);
    tick();
    n_vec++;
    if (dout_rf !== 8'd45 || val_rf !== 1'b1 || dout_wf !== 8'd45 || val_wf !== 1'b1) begin
      n_err++;
      $display("FAIL read_addr1: rf=%0d/%b wf=%0d/%b, required 45/1",
               dout_rf, val_rf, dout_wf, val_wf);
    end
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    tick();
    drive(1'b1, 1'b0, 4'd1, 8'd0);
    tick();
    n_vec++;
    if (dout_rf !== 8'd45 || val_rf !== 1'b1) begin
      n_err++;
      $display("FAIL reread_addr1: douta=%0d valid=%b, required 45/1", dout_rf, val_rf);
    end
  endtask

  task automatic test_enable_gating();
    drive(1'b1, 1'b1, 4'd14, 8'd77);
    tick();
    n_vec++;
    if (dout_rf !== 8'd0 || dout_wf !== 8'd77 || val_rf !== 1'b0 || val_wf !== 1'b0) begin
      n_err++;
      $display("FAIL write14: rf=%0d/%b wf=%0d/%b, required 0/0 and 77/0",
               dout_rf, val_rf, dout_wf, val_wf);
    end
    drive(1'b0, 1'b1, 4'd14, 8'd0);
    tick();
    n_vec++;
    if (dout_rf !== 8'd0 || dout_wf !== 8'd77 || val_rf !== 1'b0 || val_wf !== 1'b0) begin
      n_err++;
      $display("FAIL gated_write: rf=%0d/%b wf=%0d/%b, required 0/0 and 77/0",
               dout_rf, val_rf, dout_wf, val_wf);
    end
    drive(1'b1, 1'b0, 4'd14, 8'd0);
    tick();
    n_vec++;
    if (dout_rf !== 8'd77 || val_rf !== 1'b1) begin
      n_err++;
      $display("FAIL read14: douta=%0d valid=%b, required 77/1", dout_rf, val_rf);
    end
    drive(1'b0, 1'b0, 4'd3, 8'd5);
    tick();
    n_vec++;
    if (dout_rf !== 8'd77 || val_rf !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: douta=%0d valid=%b, required 77/0", dout_rf, val_rf);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b1, 4'd0, 8'd56);
    tick();
    n_vec++;
    if (dout_rf !== 8'd23 || val_rf !== 1'b0 || dout_wf !== 8'd56 || val_wf !== 1'b0) begin
      n_err++;
      $display("FAIL collision: rf=%0d/%b wf=%0d/%b, required 23/0 and 56/0",
               dout_rf, val_rf, dout_wf, val_wf);
    end
    drive(1'b1, 1'b0, 4'd0, 8'd0);
    tick();
    n_vec++;
    if (dout_rf !== 8'd56 || dout_wf !== 8'd56 || val_rf !== 1'b1 || val_wf !== 1'b1) begin
      n_err++;
      $display("FAIL post_collision: rf=%0d/%b wf=%0d/%b, required 56/1",
               dout_rf, val_rf, dout_wf, val_wf);
    end
  endtask

  task automatic test_latency2();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'd23;
    exp_d[1] = 8'd45;
    exp_d[2] = 8'd89;
    drive(1'b1, 1'b1, 4'd0, 8'd23);
    tick();
    drive(1'b1, 1'b1, 4'd15, 8'd89);
    tick();
    drive(1'b1, 1'b0, 4'd0, 8'd0);
    tick();
    n_vec++;
    if (val_l2 !== 1'b0) begin
      n_err++;
      $display("FAIL l2_first_edge: valid=%b, required 0", val_l2);
    end
    drive(1'b1, 1'b0, 4'd1, 8'd0);
    tick();
    drive(1'b1, 1'b0, 4'd15, 8'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (dout_l2 !== exp_d[i] || val_l2 !== 1'b1) begin
        n_err++;
        $display("FAIL l2_burst[%0d]: douta=%0d valid=%b, required %0d/1",
                 i, dout_l2, val_l2, exp_d[i]);
      end
      if (i == 0) tick();
      else begin
        drive(1'b0, 1'b0, 4'd0, 8'd0);
        tick();
      end
    end
    n_vec++;
    if (val_l2 !== 1'b0 || dout_l2 !== 8'd89) begin
      n_err++;
      $display("FAIL l2_burst_end: douta=%0d valid=%b, required 89/0", dout_l2, val_l2);
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 1'b1, 4'd5, 8'd99);
    tick();
    drive(1'b1, 1'b0, 4'd5, 8'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({dout_l2, val_l2, busy_l2} !== {8'h00, 1'b0, 1'b1} ||
        {dout_rf, val_rf, busy_rf} !== {8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midop_flush: l2=%h/%b/%b rf=%h/%b/%b, required 00/0/1",
               dout_l2, val_l2, busy_l2, dout_rf, val_rf, busy_rf);
    end
    tick();
    #2;
    rst = 1'b0;
    drive(1'b1, 1'b1, 4'd5, 8'h11);
    wait_clear("midop_clear_length");
    drive(1'b1, 1'b0, 4'd5, 8'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    n_vec++;
    if (dout_rf !== 8'h00 || val_rf !== 1'b1) begin
      n_err++;
      $display("FAIL midop_read5: douta=%h valid=%b, required 00/1", dout_rf, val_rf);
    end
    tick();
    n_vec++;
    if (dout_l2 !== 8'h00 || val_l2 !== 1'b1) begin
      n_err++;
      $display("FAIL midop_read5_l2: douta=%h valid=%b, required 00/1", dout_l2, val_l2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_enable_gating();
    test_collision();
    test_latency2();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_sp_responder.md
Name: ram_sp_responder

Overview:
- Synthesizable single-port block-RAM responder that serves the en/we/addr/din request interface driven by the lab2 RAM initiator benches.
- Pin-compatible with the Vivado single-port block memory, so a bench can drive either one unchanged.
- Adds a post-reset clear sequencer, selectable output-register latency, selectable read/write collision mode, and a read-valid strobe.
- Sits between a request initiator (bench, FIFO controller or datapath) and the storage array.

Parameters:
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
DATA_W, 8, data word width
LATENCY, 1, read latency in clock edges; legal values 1 or 2 (2 = extra output register)
WRITE_MODE, 0, collision behaviour on write: 0 = read-first (douta shows old word), 1 = write-first (douta shows new word)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous active-high reset
ena  input  1  access enable; a request is accepted only when ena=1 and busy=0
wea  input  1  write enable, qualified by ena
addra  input  ADDR_W  access address
dina  input  DATA_W  write data
douta  output  DATA_W  read data, registered
dout_valid  output  1  one-cycle strobe marking a read result on douta
busy  output  1  high while the clear sequence runs; requests are ignored

Behaviour:
- Clock and reset: single clock domain (clk). Reset (rst) is asynchronous and active-high.
- While rst=1:
  - douta=0, dout_valid=0, busy=1.
  - Pipeline registers = 0; FSM = CLEAR; clear counter = 0.
  - Array contents are not touched asynchronously.
- FSM has two states, CLEAR and READY.
- CLEAR state:
  - Each edge writes 0 to mem[clear_cnt], then clear_cnt+1.
  - After writing DEPTH-1, move to READY. This takes exactly DEPTH edges after rst deasserts; busy falls on edge DEPTH.
  - ena/wea/addra/dina are ignored. douta holds 0, dout_valid stays 0.
- READY state, rising edge with ena=1:
  - If wea=1: mem[addra] <= dina.
  - Stage-1 data register loads mem[addra] (old word) when WRITE_MODE=0.
  - Stage-1 loads dina when WRITE_MODE=1 and wea=1; otherwise it loads mem[addra].
  - Stage-1 valid <= ~wea.
- READY state, edge with ena=0:
  - No write occurs, even if wea=1.
  - Stage-1 data holds its previous value; stage-1 valid <= 0.
- LATENCY=1:
  - douta = stage-1 data, i.e. it updates on the same edge that samples the request.
  - dout_valid = stage-1 valid.
- LATENCY=2:
  - Stage-2 register loads stage-1 data and valid on every READY edge.
  - douta/dout_valid come from stage 2, one edge later than LATENCY=1.
- Back-to-back accesses are fully pipelined at one request per cycle, with no stalls.
- Address range: every addra value maps to a real word (DEPTH = 2**ADDR_W), so no out-of-range case exists.
- Reset mid-operation:
  - Any rst assertion, in CLEAR or READY, flushes the pipeline; in-flight reads are lost (dout_valid never pulses for them).
  - The clear sequence restarts at address 0.
- Simultaneous write and read of the same address in one cycle is resolved only by WRITE_MODE; no other hazard exists on a single port.

Test Plan:
- Clear check: pulse rst, then hold ena=0 → busy=1 for exactly 16 edges then 0. Next, read addr 15 → douta=0x00, dout_valid=1 one edge after the request (LATENCY=1).
- Write then read: write addr0←23 and addr1←45; then ena=1 we=0 addr1 din=79 → douta=45, dout_valid=1; a later read of addr1 still returns 45, proving din was ignored on the read.
- Enable gating: write addr14←77. Then ena=0 we=1 addr14 din=0 → douta unchanged and dout_valid=0. Then read addr14 → 77. Also ena=0 we=0 → douta holds its last value.
- Collision: with mem[0]=23, apply ena=1 we=1 addr0 din=56 → douta=23 for WRITE_MODE=0, or douta=56 for WRITE_MODE=1; dout_valid=0 in both. A following read of addr0 → 56 in both modes.
- Latency 2: LATENCY=2. Back-to-back reads of addr0 (23), addr1 (45), addr15 (89) → douta shows 23, 45, 89 on consecutive edges starting two edges after the first request, with dout_valid high for three cycles.
- Reset mid-operation: write addr5←99, then issue a read and assert rst before it reaches douta → douta=0 and dout_valid=0 immediately, busy=1. A write addr5←0x11 during busy is dropped. After 16 edges, read addr5 → 0x00.
